// File: rtl/select_mem_port.sv
// select_mem_port: memory access sequencer fed by the select register.
//
// Samples the selected address, write data and access kind on a read or write
// command, then holds a req/ack handshake with the main store. Read data is
// kept in a holding register; completion is a one-cycle mem_done pulse.
//
// Optional feature macro: SELECT_MEM_TIMEOUT_EN
//   defined   - REQ gives up after TIMEOUT_CYCLES cycles without ack, mem_err=1
//   undefined - REQ waits indefinitely, mem_err tied low, no counter
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   do_mem_read/write     command strobes (write wins if both high)
//   reg_select_value      address sampled on an accepted command
//   write_data            data sampled on an accepted command
//   mem_req/we/addr/wdata request to the memory, all registered
//   mem_ack, mem_rdata    memory completion and read data
//   read_data             last successfully read word
//   mem_busy              sequencer not idle
//   mem_done, mem_err     completion pulse and its timeout qualifier
module select_mem_port #(
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  do_mem_read,
    input  logic                  do_mem_write,
    input  logic [ADDR_WIDTH-1:0] reg_select_value,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  mem_busy,
    output logic                  mem_done,
    output logic                  mem_err
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e                state_q, state_d;
    logic                  req_q, req_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

`ifdef SELECT_MEM_TIMEOUT_EN
    // Counter value on the REQ edge that exhausts the wait budget.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
`ifdef SELECT_MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (do_mem_write || do_mem_read) begin
                    state_d = StReq;
                    we_d    = do_mem_write;
                    addr_d  = reg_select_value;
                    wdata_d = write_data;
`ifdef SELECT_MEM_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            StReq: begin
                // Ack on the limit edge still wins over the timeout.
                if (mem_ack) begin
                    state_d = StDone;
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                end
`ifdef SELECT_MEM_TIMEOUT_EN
                else if (cnt_q == TimeoutLast) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Status outputs are flopped copies of the next state.
        req_d  = (state_d == StReq);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef SELECT_MEM_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign mem_err = err_q;
`else
    assign mem_err = 1'b0;
`endif

    assign mem_req   = req_q;
    assign mem_busy  = busy_q;
    assign mem_done  = done_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign read_data = rdata_q;

endmodule
